// File: rtl/bus_arbiter_n_if.sv
// Bus bundle between NUM_MASTERS requesters, the arbiter and the single QSPI memory port.
// The arbiter attaches through the master modport; the requester/memory side uses slave.
interface bus_arbiter_n_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADR_W       = 32,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]        m_read_req;
  logic [NUM_MASTERS-1:0]        m_read_w;
  logic [NUM_MASTERS-1:0]        m_read_hw;
  logic [NUM_MASTERS*ADR_W-1:0]  m_read_adr;
  logic [NUM_MASTERS-1:0]        m_write_req;
  logic [NUM_MASTERS-1:0]        m_write_w;
  logic [NUM_MASTERS-1:0]        m_write_hw;
  logic [NUM_MASTERS*ADR_W-1:0]  m_write_adr;
  logic [NUM_MASTERS*DATA_W-1:0] m_write_data;
  logic [NUM_MASTERS-1:0]        m_read_valid;
  logic [NUM_MASTERS-1:0]        m_write_finish;
  logic [DATA_W-1:0]             m_read_data;
  logic                          m_error;

  logic                          read_req;
  logic                          read_w;
  logic                          read_hw;
  logic [ADR_W-1:0]              read_adr;
  logic                          read_valid;
  logic [DATA_W-1:0]             read_data;
  logic                          write_req;
  logic                          write_w;
  logic                          write_hw;
  logic [ADR_W-1:0]              write_adr;
  logic [DATA_W-1:0]             write_data;
  logic                          write_finish;

  modport master (
    input  m_read_req, m_read_w, m_read_hw, m_read_adr,
    input  m_write_req, m_write_w, m_write_hw, m_write_adr, m_write_data,
    output m_read_valid, m_write_finish, m_read_data, m_error,
    output read_req, read_w, read_hw, read_adr,
    input  read_valid, read_data,
    output write_req, write_w, write_hw, write_adr, write_data,
    input  write_finish
  );

  modport slave (
    output m_read_req, m_read_w, m_read_hw, m_read_adr,
    output m_write_req, m_write_w, m_write_hw, m_write_adr, m_write_data,
    input  m_read_valid, m_write_finish, m_read_data, m_error,
    input  read_req, read_w, read_hw, read_adr,
    output read_valid, read_data,
    input  write_req, write_w, write_hw, write_adr, write_data,
    output write_finish
  );
endinterface

// File: rtl/bus_arbiter_n.sv
// N-master arbiter serialising read/write requests onto one memory port (round-robin or fixed priority).
// Optional watchdog on the WAIT state is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_n #(
  parameter int NUM_MASTERS    = 3,
  parameter int ADR_W          = 32,
  parameter int DATA_W         = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  bus_arbiter_n_if.master  bus
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  logic [ADR_W-1:0]  rd_adr  [NUM_MASTERS];
  logic [ADR_W-1:0]  wr_adr  [NUM_MASTERS];
  logic [DATA_W-1:0] wr_data [NUM_MASTERS];

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign rd_adr[gi]  = bus.m_read_adr[gi*ADR_W +: ADR_W];
      assign wr_adr[gi]  = bus.m_write_adr[gi*ADR_W +: ADR_W];
      assign wr_data[gi] = bus.m_write_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic              is_write_q, is_write_d;
  logic              read_req_q, read_req_d;
  logic              read_w_q, read_w_d;
  logic              read_hw_q, read_hw_d;
  logic [ADR_W-1:0]  read_adr_q, read_adr_d;
  logic              write_req_q, write_req_d;
  logic              write_w_q, write_w_d;
  logic              write_hw_q, write_hw_d;
  logic [ADR_W-1:0]  write_adr_q, write_adr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] grant_oh;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       rr_idx;
  logic                   rd_hit, wr_hit, timeout_hit, done_hit;

  assign eligible = bus.m_read_req | bus.m_write_req;

  // Scan downward so the last hit is the lowest index (fixed) or nearest after last_q (RR).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (eligible[IDX_W'(i)]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        rr_idx = IDX_W'((int'(last_q) + k) % NUM_MASTERS);
        if (eligible[rr_idx]) begin
          win_found = 1'b1;
          win_idx   = rr_idx;
        end
      end
    end
  end

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  assign rd_hit = (state_q == S_WAIT) && !is_write_q && bus.read_valid;
  assign wr_hit = (state_q == S_WAIT) &&  is_write_q && bus.write_finish;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE)     cnt_d = '0;
    else if (state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign done_hit = rd_hit | wr_hit | timeout_hit;

  assign bus.m_read_valid   = (rd_hit || (timeout_hit && !is_write_q)) ? grant_oh : '0;
  assign bus.m_write_finish = (wr_hit || (timeout_hit &&  is_write_q)) ? grant_oh : '0;
  assign bus.m_read_data    = timeout_hit ? DATA_W'(32'hDEADBEEF) : bus.read_data;
  assign bus.m_error        = timeout_hit;

  assign bus.read_req   = read_req_q;
  assign bus.read_w     = read_w_q;
  assign bus.read_hw    = read_hw_q;
  assign bus.read_adr   = read_adr_q;
  assign bus.write_req  = write_req_q;
  assign bus.write_w    = write_w_q;
  assign bus.write_hw   = write_hw_q;
  assign bus.write_adr  = write_adr_q;
  assign bus.write_data = write_data_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    is_write_d   = is_write_q;
    read_req_d   = 1'b0;
    write_req_d  = 1'b0;
    read_w_d     = read_w_q;
    read_hw_d    = read_hw_q;
    read_adr_d   = read_adr_q;
    write_w_d    = write_w_q;
    write_hw_d   = write_hw_q;
    write_adr_d  = write_adr_q;
    write_data_d = write_data_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d    = win_idx;
          // A master with both requests pending gets its write first.
          is_write_d = bus.m_write_req[win_idx];
          if (ARB_MODE == 0) last_d = win_idx;
          if (bus.m_write_req[win_idx]) begin
            write_req_d  = 1'b1;
            write_w_d    = bus.m_write_w[win_idx];
            write_hw_d   = bus.m_write_hw[win_idx];
            write_adr_d  = wr_adr[win_idx];
            write_data_d = wr_data[win_idx];
          end else begin
            read_req_d = 1'b1;
            read_w_d   = bus.m_read_w[win_idx];
            read_hw_d  = bus.m_read_hw[win_idx];
            read_adr_d = rd_adr[win_idx];
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (done_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_q       <= IDX_W'(NUM_MASTERS - 1);
      is_write_q   <= 1'b0;
      read_req_q   <= 1'b0;
      read_w_q     <= 1'b0;
      read_hw_q    <= 1'b0;
      read_adr_q   <= '0;
      write_req_q  <= 1'b0;
      write_w_q    <= 1'b0;
      write_hw_q   <= 1'b0;
      write_adr_q  <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      is_write_q   <= is_write_d;
      read_req_q   <= read_req_d;
      read_w_q     <= read_w_d;
      read_hw_q    <= read_hw_d;
      read_adr_q   <= read_adr_d;
      write_req_q  <= write_req_d;
      write_w_q    <= write_w_d;
      write_hw_q   <= write_hw_d;
      write_adr_q  <= write_adr_d;
      write_data_q <= write_data_d;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n: a round-robin instance (timeout 16) and a fixed-priority instance.
module tb_bus_arbiter_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bus_arbiter_n_if #(.NUM_MASTERS(3), .ADR_W(32), .DATA_W(32)) rr_if ();
  bus_arbiter_n_if #(.NUM_MASTERS(3), .ADR_W(32), .DATA_W(32)) fp_if ();

  bus_arbiter_n #(.NUM_MASTERS(3), .ADR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT_CYCLES(16))
    u_rr (.clk(clk), .rst(rst), .bus(rr_if));
  bus_arbiter_n #(.NUM_MASTERS(3), .ADR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT_CYCLES(16))
    u_fp (.clk(clk), .rst(rst), .bus(fp_if));

  typedef struct {
    logic [1:0]  m;
    bit          wr;
    logic [31:0] adr;
    bit          w;
    bit          hw;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic [2:0]  exp_pulse;
  } vec_t;

  vec_t       vecs [5];
  logic [1:0] rr_exp [4];
  logic [1:0] fp_exp [3];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rr();
    rr_if.m_read_req = '0;  rr_if.m_read_w = '0;  rr_if.m_read_hw = '0;  rr_if.m_read_adr = '0;
    rr_if.m_write_req = '0; rr_if.m_write_w = '0; rr_if.m_write_hw = '0; rr_if.m_write_adr = '0;
    rr_if.m_write_data = '0;
    rr_if.read_valid = 1'b0; rr_if.read_data = '0; rr_if.write_finish = 1'b0;
  endtask

  // Called in an IDLE cycle with requests set; returns in the DONE cycle.
  task automatic serve(input string tag, input bit wr, input logic [31:0] adr, input int lat,
                       input logic [31:0] rdata, input logic [2:0] exp_pulse);
    cycle();
    chk({tag, " strobe"}, wr ? rr_if.write_req : rr_if.read_req, 1);
    chk({tag, " other strobe"}, wr ? rr_if.read_req : rr_if.write_req, 0);
    chk({tag, " adr"}, wr ? rr_if.write_adr : rr_if.read_adr, adr);
    repeat (lat) cycle();
    chk({tag, " strobe width"}, {rr_if.read_req, rr_if.write_req}, 0);
    if (wr) rr_if.write_finish = 1'b1;
    else begin
      rr_if.read_valid = 1'b1;
      rr_if.read_data  = rdata;
    end
    #1;
    chk({tag, " pulse"}, wr ? rr_if.m_write_finish : rr_if.m_read_valid, exp_pulse);
    chk({tag, " other pulse"}, wr ? rr_if.m_read_valid : rr_if.m_write_finish, 0);
    if (!wr) chk({tag, " rdata"}, rr_if.m_read_data, rdata);
    chk({tag, " error"}, rr_if.m_error, 0);
    cycle();
    rr_if.read_valid = 1'b0; rr_if.read_data = '0; rr_if.write_finish = 1'b0;
  endtask

  initial begin
    logic early;

    vecs[0] = '{m:2'd1, wr:1'b0, adr:32'h0000_1000, w:1'b1, hw:1'b0, wdata:32'h0,
                lat:5, rdata:32'h1234_5678, exp_pulse:3'b010};
    vecs[1] = '{m:2'd0, wr:1'b1, adr:32'h0000_2000, w:1'b0, hw:1'b1, wdata:32'h0000_CAFE,
                lat:2, rdata:32'h0, exp_pulse:3'b001};
    vecs[2] = '{m:2'd2, wr:1'b0, adr:32'h0000_3003, w:1'b0, hw:1'b0, wdata:32'h0,
                lat:1, rdata:32'h0000_00AB, exp_pulse:3'b100};
    vecs[3] = '{m:2'd2, wr:1'b1, adr:32'h0000_4000, w:1'b1, hw:1'b0, wdata:32'h1122_3344,
                lat:3, rdata:32'h0, exp_pulse:3'b100};
    vecs[4] = '{m:2'd1, wr:1'b1, adr:32'h0000_5000, w:1'b0, hw:1'b0, wdata:32'h0000_005A,
                lat:1, rdata:32'h0, exp_pulse:3'b010};
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0};
    fp_exp = '{2'd0, 2'd0, 2'd2};

    clear_rr();
    fp_if.m_read_req = '0;  fp_if.m_read_w = '0;  fp_if.m_read_hw = '0;  fp_if.m_read_adr = '0;
    fp_if.m_write_req = '0; fp_if.m_write_w = '0; fp_if.m_write_hw = '0; fp_if.m_write_adr = '0;
    fp_if.m_write_data = '0;
    fp_if.read_valid = 1'b0; fp_if.read_data = '0; fp_if.write_finish = 1'b0;

    // Reset state
    rst = 1'b1;
    cycle();
    chk("reset read_req", rr_if.read_req, 0);
    chk("reset write_req", rr_if.write_req, 0);
    chk("reset read_adr", rr_if.read_adr, 0);
    chk("reset write_adr", rr_if.write_adr, 0);
    chk("reset write_data", rr_if.write_data, 0);
    chk("reset sizes", {rr_if.read_w, rr_if.read_hw, rr_if.write_w, rr_if.write_hw}, 0);
    chk("reset pulses", {rr_if.m_read_valid, rr_if.m_write_finish, rr_if.m_error}, 0);
    rst = 1'b0;

    // Single transactions from the vector table
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].wr) begin
        rr_if.m_write_req[vecs[i].m] = 1'b1;
        rr_if.m_write_w[vecs[i].m]   = vecs[i].w;
        rr_if.m_write_hw[vecs[i].m]  = vecs[i].hw;
        rr_if.m_write_adr[int'(vecs[i].m)*32 +: 32]  = vecs[i].adr;
        rr_if.m_write_data[int'(vecs[i].m)*32 +: 32] = vecs[i].wdata;
      end else begin
        rr_if.m_read_req[vecs[i].m] = 1'b1;
        rr_if.m_read_w[vecs[i].m]   = vecs[i].w;
        rr_if.m_read_hw[vecs[i].m]  = vecs[i].hw;
        rr_if.m_read_adr[int'(vecs[i].m)*32 +: 32] = vecs[i].adr;
      end
      serve($sformatf("vec%0d", i), vecs[i].wr, vecs[i].adr, vecs[i].lat, vecs[i].rdata,
            vecs[i].exp_pulse);
      chk($sformatf("vec%0d size w", i), vecs[i].wr ? rr_if.write_w : rr_if.read_w, vecs[i].w);
      chk($sformatf("vec%0d size hw", i), vecs[i].wr ? rr_if.write_hw : rr_if.read_hw, vecs[i].hw);
      if (vecs[i].wr) chk($sformatf("vec%0d wdata", i), rr_if.write_data, vecs[i].wdata);
      clear_rr();
      cycle();
    end

    // Master 0 read and write together: write first, read on the next grant
    rr_if.m_read_req[0] = 1'b1;  rr_if.m_read_adr[31:0]  = 32'h0000_6000; rr_if.m_read_w[0] = 1'b1;
    rr_if.m_write_req[0] = 1'b1; rr_if.m_write_adr[31:0] = 32'h0000_7000; rr_if.m_write_w[0] = 1'b1;
    rr_if.m_write_data[31:0] = 32'hA5A5_0001;
    serve("rw write first", 1'b1, 32'h0000_7000, 2, 32'h0, 3'b001);
    rr_if.m_write_req[0] = 1'b0;
    cycle();
    serve("rw read later", 1'b0, 32'h0000_6000, 2, 32'h0BAD_F00D, 3'b001);
    clear_rr();
    cycle();

    // Stray completions in IDLE, ISSUE and DONE; wrong-type completion in WAIT
    rr_if.read_valid = 1'b1;
    #1;
    chk("stray idle pulse", rr_if.m_read_valid, 0);
    cycle();
    rr_if.read_valid = 1'b0;
    chk("stray idle no issue", rr_if.read_req, 0);
    rr_if.m_read_req[1] = 1'b1; rr_if.m_read_adr[63:32] = 32'h0000_8000;
    cycle();
    chk("stray issue strobe", rr_if.read_req, 1);
    rr_if.read_valid = 1'b1;
    #1;
    chk("stray issue pulse", rr_if.m_read_valid, 0);
    cycle();
    rr_if.read_valid = 1'b0; rr_if.write_finish = 1'b1;
    #1;
    chk("wrong type finish", {rr_if.m_read_valid, rr_if.m_write_finish}, 0);
    cycle();
    rr_if.write_finish = 1'b0; rr_if.read_valid = 1'b1; rr_if.read_data = 32'h0000_55AA;
    #1;
    chk("after wrong type pulse", rr_if.m_read_valid, 3'b010);
    chk("after wrong type rdata", rr_if.m_read_data, 32'h0000_55AA);
    cycle();
    #1;
    chk("stray done pulse", rr_if.m_read_valid, 0);
    clear_rr();
    cycle();

    // Master drops its request mid-WAIT: completion still reaches it
    rr_if.m_read_req[2] = 1'b1; rr_if.m_read_adr[95:64] = 32'h0000_9000;
    cycle();
    chk("drop strobe", rr_if.read_req, 1);
    cycle();
    rr_if.m_read_req[2] = 1'b0;
    cycle();
    rr_if.read_valid = 1'b1; rr_if.read_data = 32'h0000_9999;
    #1;
    chk("drop pulse", rr_if.m_read_valid, 3'b100);
    cycle();
    clear_rr();
    cycle();
    cycle();
    chk("drop no reissue", {rr_if.read_req, rr_if.write_req}, 0);

    // Round-robin: all three hold writes from reset, expected order 0,1,2,0
    rst = 1'b1;
    rr_if.m_write_req = 3'b111;
    rr_if.m_write_adr = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
    cycle();
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      serve($sformatf("rr grant%0d", r), 1'b1, 32'h0000_00A0 + 32'(rr_exp[r]), 1, 32'h0,
            3'b001 << rr_exp[r]);
      if (r == 3) rr_if.m_write_req = '0;
      else        rr_if.m_write_req[rr_exp[r]] = 1'b0;
      cycle();
      if (r < 3) rr_if.m_write_req[rr_exp[r]] = 1'b1;
    end
    clear_rr();

    // Fixed priority: master 2 waits while master 0 keeps re-requesting
    rst = 1'b1;
    fp_if.m_read_req = 3'b101;
    fp_if.m_read_adr = {32'h0000_00B2, 32'h0000_0000, 32'h0000_00B0};
    cycle();
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      cycle();
      chk($sformatf("fp strobe%0d", r), fp_if.read_req, 1);
      chk($sformatf("fp adr%0d", r), fp_if.read_adr, (fp_exp[r] == 2'd0) ? 32'h0000_00B0 : 32'h0000_00B2);
      cycle();
      fp_if.read_valid = 1'b1;
      #1;
      chk($sformatf("fp pulse%0d", r), fp_if.m_read_valid, 3'b001 << fp_exp[r]);
      cycle();
      fp_if.read_valid = 1'b0;
      fp_if.m_read_req[fp_exp[r]] = 1'b0;
      cycle();
      if (r == 0) fp_if.m_read_req[0] = 1'b1;
    end

`ifdef ARB_TIMEOUT_EN
    // Silent slave: forced completion 16 cycles after read_req
    rr_if.m_read_req[0] = 1'b1; rr_if.m_read_adr[31:0] = 32'h0000_00C0;
    cycle();
    chk("to strobe", rr_if.read_req, 1);
    early = 1'b0;
    repeat (15) begin
      cycle();
      early = early | (|rr_if.m_read_valid) | rr_if.m_error;
    end
    chk("to early", early, 0);
    cycle();
    chk("to pulse", rr_if.m_read_valid, 3'b001);
    chk("to error", rr_if.m_error, 1);
    chk("to data", rr_if.m_read_data, 32'hDEAD_BEEF);
    cycle();
    rr_if.m_read_req = '0;
    rr_if.read_valid = 1'b1;
    #1;
    chk("to late ignored", rr_if.m_read_valid, 0);
    cycle();
    rr_if.read_valid = 1'b0;
    rr_if.m_write_req[1] = 1'b1; rr_if.m_write_adr[63:32] = 32'h0000_00D0;
    serve("to next", 1'b1, 32'h0000_00D0, 2, 32'h0, 3'b010);
    clear_rr();
    cycle();
`else
    early = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
Parametrised N-master successor to the fixed three-source bus gather. Takes read and write requests from NUM_MASTERS requesters (CPU I-fetch, CPU data, UART loader, future DMA) and serialises them onto the single QSPI memory port. Supports round-robin or fixed-priority arbitration and routes completions back to the granted master only. Sits between the requesters and qspi_if in the FPGA top.

Parameters:
NUM_MASTERS, 3, number of requesters (2..8)
ADR_W, 32, address width
DATA_W, 32, data width
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (index 0 highest)
TIMEOUT_CYCLES, 4096, watchdog limit; used only with ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
m_read_req  in  NUM_MASTERS  per-master read request level
m_read_w  in  NUM_MASTERS  read size word
m_read_hw  in  NUM_MASTERS  read size halfword (neither set = byte)
m_read_adr  in  NUM_MASTERS*ADR_W  packed read addresses, master i at [i*ADR_W +: ADR_W]
m_write_req  in  NUM_MASTERS  per-master write request level
m_write_w  in  NUM_MASTERS  write size word
m_write_hw  in  NUM_MASTERS  write size halfword
m_write_adr  in  NUM_MASTERS*ADR_W  packed write addresses
m_write_data  in  NUM_MASTERS*DATA_W  packed write data
m_read_valid  out  NUM_MASTERS  per-master read completion pulse
m_write_finish  out  NUM_MASTERS  per-master write completion pulse
m_read_data  out  DATA_W  read data, broadcast to all masters
m_error  out  1  completion was a timeout abort (ARB_TIMEOUT_EN only, else tied 0)
read_req  out  1  downstream read strobe, 1-cycle pulse
read_w / read_hw  out  1 / 1  downstream read size
read_adr  out  ADR_W  downstream read address
read_valid  in  1  downstream read done
read_data  in  DATA_W  downstream read data
write_req  out  1  downstream write strobe, 1-cycle pulse
write_w / write_hw  out  1 / 1  downstream write size
write_adr  out  ADR_W  downstream write address
write_data  out  DATA_W  downstream write data
write_finish  in  1  downstream write done

Behaviour:
- Reset: all outputs 0; FSM in IDLE; RR pointer last = NUM_MASTERS-1, so master 0 wins first.
- Master contract: req is a level, held with stable attributes until that master's completion pulse. The master drops req the cycle after the completion pulse.
- FSM states:
  - IDLE: any req pending -> ISSUE. Winner and type are latched into registers.
  - ISSUE: read_req or write_req pulses for exactly 1 cycle -> WAIT.
  - WAIT: the matching read_valid or write_finish arrives -> DONE.
  - DONE: lasts 1 cycle -> IDLE.
- Latency: req seen in IDLE at cycle t -> downstream strobe at t+1.
- Completion pass-through: downstream completion at cycle c -> m_read_valid[g] or m_write_finish[g] at c, combinational, masked by granted index g. m_read_data = read_data.
- Next arbitration is evaluated at c+2.
- Downstream address, size and data outputs are registered from the latched winner. They stay stable from ISSUE through WAIT, hold through DONE, and are zeroed only by reset.
- Winner selection:
  - A master is eligible if m_read_req[i] | m_write_req[i].
  - RR: first eligible index scanning last+1 upward with wrap; last updates to winner in IDLE.
  - Fixed: lowest eligible index.
- If a master has both read and write pending, the write is served first; the read is served on a later grant.
- Boundary rules:
  - Completion while in IDLE, ISSUE or DONE: ignored, no master pulse.
  - Wrong-type completion in WAIT (e.g. write_finish during a read): ignored.
  - Master drops req mid-WAIT: the transaction still completes and its pulse is still issued.
  - rst asserted mid-WAIT: immediate return to the reset state; the downstream transaction is abandoned.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a counter clears on ISSUE and increments in WAIT. Reaching TIMEOUT_CYCLES-1 forces completion: the granted master's pulse fires, m_read_data = 32'hDEADBEEF for reads, m_error = 1 for that cycle, and the FSM goes to DONE. A late downstream completion is ignored by the IDLE/ISSUE/DONE rule.
- Undefined: no counter; WAIT has no timeout; m_error is constant 0.

Test Plan:
1. Master 1 read 0x0000_1000, word; slave returns 0x1234_5678 after 5 cycles -> read_req pulse 1 cycle after request, read_adr = 0x1000, m_read_valid = 3'b010 with m_read_data = 0x1234_5678, no other pulses.
2. RR mode, all three masters hold write requests from reset -> grant order 0,1,2,0; each write_finish pulses only the corresponding m_write_finish bit.
3. ARB_MODE=1, masters 0 and 2 continuously re-request -> master 2 is never granted while 0 is pending; master 2 is granted when 0 idles.
4. Master 0 raises read and write together -> write issued first (write_adr matches); read issued on a later grant.
5. Stray read_valid in IDLE, then write_finish during a read WAIT -> no master pulse for either; the read completes normally on read_valid.
6. ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, slave never responds to a read -> m_read_valid and m_error pulse 16 cycles after read_req with data 0xDEADBEEF, then the next request is served.
